// File: rtl/ace_ccu_snoop_lookup_table_if.sv
// -----------------------------------------------------------------------------
// ace_ccu_snoop_lookup_table_if
//
// Purpose:
//   Bundles the lookup handshake and the clear/status signals of the CCU snoop
//   lookup table. The snoop interconnect is the master. The lookup table is
//   the slave.
//
// Handshake semantics (lookup):
//   - A requester raises lup_valid[i] with lup_addr[i].
//   - It holds both stable until it sees lup_ready[i] high in the same cycle.
//   - A transfer happens on a clock edge where lup_valid[i] && lup_ready[i].
//   - lup_id is the allocated entry index, meaningful only while some
//     lup_ready bit is high.
//   - Dropping lup_valid before a grant is allowed and leaves no trace.
//   - lup_ready is one-hot or zero.
//   - lup_ready depends combinationally on lup_valid/lup_addr and on
//     registered state only.
//   - clr_valid is a single-cycle command with no back-pressure. Its effect,
//     or the error pulse on clr_err, is visible after the next edge.
//
// Signals:
//   lup_valid  [NumLup]            master -> slave  per-port lookup request
//   lup_addr   [NumLup][AddrWidth] master -> slave  per-port snoop address
//   lup_ready  [NumLup]            slave  -> master per-port grant
//   lup_id     [IdWidth]           slave  -> master allocated entry index
//   clr_valid                      master -> slave  free-entry command
//   clr_id     [IdWidth]           master -> slave  entry to free
//   clr_err                        slave  -> master one-cycle bad-clear pulse
//   occupancy  [OccWidth]          slave  -> master number of valid entries
// -----------------------------------------------------------------------------
interface ace_ccu_snoop_lookup_table_if #(
    parameter int unsigned NumLup     = 2,
    parameter int unsigned NumEntries = 4,
    parameter int unsigned AddrWidth  = 64
);
    localparam int unsigned IdWidth  = (NumEntries > 1) ? $clog2(NumEntries) : 1;
    localparam int unsigned OccWidth = $clog2(NumEntries + 1);

    logic [NumLup-1:0]                lup_valid;
    logic [NumLup-1:0][AddrWidth-1:0] lup_addr;
    logic [NumLup-1:0]                lup_ready;
    logic [IdWidth-1:0]               lup_id;
    logic                             clr_valid;
    logic [IdWidth-1:0]               clr_id;
    logic                             clr_err;
    logic [OccWidth-1:0]              occupancy;

    modport master (
        output lup_valid,
        output lup_addr,
        input  lup_ready,
        input  lup_id,
        output clr_valid,
        output clr_id,
        input  clr_err,
        input  occupancy
    );

    modport slave (
        input  lup_valid,
        input  lup_addr,
        output lup_ready,
        output lup_id,
        input  clr_valid,
        input  clr_id,
        output clr_err,
        output occupancy
    );
endinterface

// File: rtl/ace_ccu_snoop_lookup_table.sv
// -----------------------------------------------------------------------------
// ace_ccu_snoop_lookup_table
//
// Purpose:
//   Address-conflict lookup controller for the CCU snoop interconnect. It
//   keeps a small table of cache-line tags that have a snoop in flight.
//   A new lookup is granted only when:
//     - its tag matches no in-flight entry, and
//     - the table has a free entry.
//   One port is granted per cycle, chosen round-robin.
//   The granted port gets the lowest-index free entry.
//   Entries are released by explicit clear commands.
//
// Ports:
//   clk_i   in  clock
//   rst_ni  in  asynchronous active-low reset
//   bus     slave modport of ace_ccu_snoop_lookup_table_if
//     (lookup handshake, clear command, clear error, occupancy)
//
// Parameters:
//   NumLup      number of lookup ports (>= 1)
//   NumEntries  number of in-flight tag entries (>= 1)
//   AddrWidth   snoop address width
//   AddrBase    LSB of the tag slice inside the address
//   AddrLength  tag width; AddrBase + AddrLength must fit in AddrWidth
// -----------------------------------------------------------------------------
module ace_ccu_snoop_lookup_table #(
    parameter int unsigned NumLup     = 2,
    parameter int unsigned NumEntries = 4,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned AddrBase   = 4,
    parameter int unsigned AddrLength = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    ace_ccu_snoop_lookup_table_if.slave   bus
);

    localparam int unsigned IdWidth  = (NumEntries > 1) ? $clog2(NumEntries) : 1;
    localparam int unsigned OccWidth = $clog2(NumEntries + 1);
    localparam int unsigned RrWidth  = (NumLup > 1) ? $clog2(NumLup) : 1;

    // The tag slice must lie inside the address.
    if (AddrBase + AddrLength > AddrWidth) begin : g_bad_tag_slice
        $error("ace_ccu_snoop_lookup_table: AddrBase + AddrLength exceeds AddrWidth");
    end

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    logic [NumEntries-1:0]  r_valid;
    logic [AddrLength-1:0]  r_tag [NumEntries];
    logic [RrWidth-1:0]     r_rr;
    logic                   r_clr_err;
    logic [OccWidth-1:0]    r_occ;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic [AddrLength-1:0]  w_lup_tag [NumLup];
    logic [NumLup-1:0]      w_match;
    logic [NumLup-1:0]      w_elig;
    logic [NumLup-1:0]      w_grant;
    logic                   w_any_grant;
    logic [RrWidth-1:0]     w_grant_idx;
    logic [RrWidth-1:0]     w_rr_next;
    logic [AddrLength-1:0]  w_grant_tag;
    logic                   w_full;
    logic [IdWidth-1:0]     w_free_idx;
    logic                   w_clr_in_range;
    logic                   w_clr_hit;

    // Tag extraction per lookup port.
    always_comb begin
        for (int i = 0; i < NumLup; i++) begin
            w_lup_tag[i] = bus.lup_addr[i][AddrBase +: AddrLength];
        end
    end

    // A port conflicts when its tag equals the tag of any valid entry.
    // Only registered state is compared. Two ports with the same tag in the
    // same cycle therefore do not see each other here. Only one can be
    // granted. The other sees the new entry next cycle and stalls.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NumLup; i++) begin
            for (int e = 0; e < NumEntries; e++) begin
                if (r_valid[e] && (r_tag[e] == w_lup_tag[i])) begin
                    w_match[i] = 1'b1;
                end
            end
        end
    end

    assign w_full = &r_valid;

    // Lowest-index free entry. The loop runs downward so the last hit is
    // the lowest index. Only used when the table is not full.
    always_comb begin
        w_free_idx = '0;
        for (int e = NumEntries - 1; e >= 0; e--) begin
            if (!r_valid[e]) begin
                w_free_idx = IdWidth'(e);
            end
        end
    end

    // Eligibility is gated with rst_ni. While reset is held, grants stay low
    // even though the grant path is combinational from the request inputs.
    always_comb begin
        for (int i = 0; i < NumLup; i++) begin
            w_elig[i] = rst_ni & bus.lup_valid[i] & ~w_match[i] & ~w_full;
        end
    end

    // Round-robin pick: first eligible port at or after r_rr, cyclically.
    always_comb begin
        int unsigned p;
        p           = 0;
        w_any_grant = 1'b0;
        w_grant_idx = '0;
        w_grant     = '0;
        for (int k = 0; k < NumLup; k++) begin
            p = (int'(r_rr) + k) % NumLup;
            if (!w_any_grant && w_elig[p]) begin
                w_any_grant = 1'b1;
                w_grant_idx = RrWidth'(p);
            end
        end
        if (w_any_grant) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    // Pointer moves to the port just after the winner, wrapping at NumLup.
    always_comb begin
        if (int'(w_grant_idx) == NumLup - 1) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_grant_idx + 1'b1;
        end
    end

    assign w_grant_tag = w_lup_tag[w_grant_idx];

    // A clear is honoured only for an in-range index of a valid entry.
    // Anything else produces the error pulse.
    assign w_clr_in_range = (int'(bus.clr_id) < NumEntries);
    assign w_clr_hit      = bus.clr_valid & w_clr_in_range & r_valid[bus.clr_id];

    // -------------------------------------------------------------------------
    // State update
    // -------------------------------------------------------------------------
    // A clear and an allocation can land on the same edge.
    //   - Allocation picked its entry from the pre-clear free set.
    //   - A successful clear only targets a valid entry.
    //   - So the two never touch the same bit of r_valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid   <= '0;
            r_rr      <= '0;
            r_clr_err <= 1'b0;
            r_occ     <= '0;
            for (int e = 0; e < NumEntries; e++) begin
                r_tag[e] <= '0;
            end
        end else begin
            r_clr_err <= bus.clr_valid & ~w_clr_hit;

            if (w_clr_hit) begin
                r_valid[bus.clr_id] <= 1'b0;
            end

            if (w_any_grant) begin
                r_valid[w_free_idx] <= 1'b1;
                r_tag[w_free_idx]   <= w_grant_tag;
                r_rr                <= w_rr_next;
            end

            case ({w_any_grant, w_clr_hit})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.lup_ready = w_grant;
    assign bus.lup_id    = w_any_grant ? w_free_idx : '0;
    assign bus.clr_err   = r_clr_err;
    assign bus.occupancy = r_occ;

endmodule
